// File: rtl/phase_accumulator_if.sv
// Control and phase-output bundle between a DDS controller (master) and phase_accumulator (slave).
// Signal prefixes i_/o_ are given from the accumulator's point of view.
interface phase_accumulator_if #(
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 12
);
    logic                 i_en;
    logic                 i_sync;
    logic [ACC_WIDTH-1:0] i_ftw;
    logic                 i_ftw_load;
    logic [OUT_WIDTH-1:0] i_offset;
    logic [OUT_WIDTH-1:0] o_phase;
    logic                 o_wrap;
    logic                 o_ftw_pending;

    modport master (
        output i_en, i_sync, i_ftw, i_ftw_load, i_offset,
        input  o_phase, o_wrap, o_ftw_pending
    );

    modport slave (
        input  i_en, i_sync, i_ftw, i_ftw_load, i_offset,
        output o_phase, o_wrap, o_ftw_pending
    );
endinterface

// File: rtl/phase_accumulator.sv
// DDS phase accumulator with shadowed FTW (applied at wrap), phase offset, sync reset and wrap strobe.
// Optional macro PHASE_DITHER_EN adds sub-LSB LFSR dither before truncation (needs ACC_WIDTH-OUT_WIDTH >= 16).
module phase_accumulator #(
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 12
) (
    input  logic               i_clk,
    input  logic               i_rst,
    phase_accumulator_if.slave bus
);

    logic [ACC_WIDTH-1:0] r_acc_p0;
    logic                 r_carry_p0;
    logic [ACC_WIDTH-1:0] r_ftw_active;
    logic [ACC_WIDTH-1:0] r_ftw_shadow;
    logic                 r_pending;
    logic [OUT_WIDTH-1:0] r_phase_p1;
    logic                 r_wrap_p1;

    logic [ACC_WIDTH-1:0] w_sum;
    logic                 w_carry;
    logic                 w_transfer;
    logic [ACC_WIDTH-1:0] w_phase_src;

    function automatic logic [OUT_WIDTH-1:0] trunc_phase(
        input logic [ACC_WIDTH-1:0] acc,
        input logic [OUT_WIDTH-1:0] off
    );
        return acc[ACC_WIDTH-1 -: OUT_WIDTH] + off;
    endfunction

    assign {w_carry, w_sum} = {1'b0, r_acc_p0} + {1'b0, r_ftw_active};

    // A pending word goes live at a wrap, on SYNC, while held, or when no frequency is running yet.
    assign w_transfer = r_pending &&
                        (bus.i_sync || !bus.i_en || (r_ftw_active == '0) || w_carry);

`ifdef PHASE_DITHER_EN
    localparam int DITHER_SHIFT = ACC_WIDTH - OUT_WIDTH - 16;
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;

    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lfsr <= 16'hACE1;
        end else if (bus.i_en && !bus.i_sync) begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    assign w_phase_src = r_acc_p0 + ({{(ACC_WIDTH-16){1'b0}}, r_lfsr} << DITHER_SHIFT);
`else
    assign w_phase_src = r_acc_p0;
`endif

    // Stage p0: accumulator, FTW shadow/active registers and raw carry
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc_p0     <= '0;
            r_carry_p0   <= 1'b0;
            r_ftw_active <= '0;
            r_ftw_shadow <= '0;
            r_pending    <= 1'b0;
        end else begin
            if (bus.i_sync) begin
                r_acc_p0 <= '0;
            end else if (bus.i_en) begin
                r_acc_p0 <= w_sum;
            end
            r_carry_p0 <= !bus.i_sync && bus.i_en && w_carry;

            if (w_transfer) begin
                r_ftw_active <= r_ftw_shadow;
            end
            // A new load keeps the flag set even when an older word transfers on this edge.
            if (bus.i_ftw_load) begin
                r_ftw_shadow <= bus.i_ftw;
                r_pending    <= 1'b1;
            end else if (w_transfer) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Stage p1: truncated phase plus offset, wrap strobe aligned with the wrapped phase
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_phase_p1 <= '0;
            r_wrap_p1  <= 1'b0;
        end else begin
            r_phase_p1 <= trunc_phase(w_phase_src, bus.i_offset);
            r_wrap_p1  <= r_carry_p0;
        end
    end

    assign bus.o_phase       = r_phase_p1;
    assign bus.o_wrap        = r_wrap_p1;
    assign bus.o_ftw_pending = r_pending;

endmodule

// File: tb/tb_phase_accumulator.sv
// Directed bench for phase_accumulator: expected PHASE/WRAP/FTW_PENDING queued per step, checked after each edge.
module tb_phase_accumulator;

    localparam int ACC_W = 32;
    localparam int OUT_W = 12;

    logic clk;
    logic rst;

    phase_accumulator_if #(.ACC_WIDTH(ACC_W), .OUT_WIDTH(OUT_W)) bus ();

    phase_accumulator #(.ACC_WIDTH(ACC_W), .OUT_WIDTH(OUT_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [OUT_W-1:0] phase;
        logic             wrap;
        logic             pend;
    } exp_t;

    exp_t  sb[$];
    int    total = 0;
    int    bad   = 0;
    int    stepn = 0;
    string tname = "init";

    task automatic chk(input string field, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s.%s step=%0d observed=%0d expected=%0d", tname, field, stepn, obs, exp);
        end
    endtask

    task automatic chk_phase(input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
        logic [OUT_W-1:0] o;
        o = obs;
`ifdef PHASE_DITHER_EN
        if (OUT_W'(obs - exp) == OUT_W'(1)) o = exp;
`endif
        chk("phase", 32'(o), 32'(exp));
    endtask

    task automatic step(input int ph, input logic wr, input logic pd);
        exp_t e;
        sb.push_back('{phase: OUT_W'(ph), wrap: wr, pend: pd});
        @(posedge clk);
        #1;
        stepn++;
        e = sb.pop_front();
        chk_phase(bus.o_phase, e.phase);
        chk("wrap", 32'(bus.o_wrap), 32'(e.wrap));
        chk("pend", 32'(bus.o_ftw_pending), 32'(e.pend));
    endtask

    task automatic reset_dut();
        rst            = 1'b1;
        bus.i_en       = 1'b0;
        bus.i_sync     = 1'b0;
        bus.i_ftw      = '0;
        bus.i_ftw_load = 1'b0;
        bus.i_offset   = '0;
        @(posedge clk);
        #1;
        chk("rst_phase", 32'(bus.o_phase), 32'd0);
        chk("rst_wrap", 32'(bus.o_wrap), 32'd0);
        chk("rst_pend", 32'(bus.o_ftw_pending), 32'd0);
        rst = 1'b0;
    endtask

    // Load a word while idle: captured on the first edge, applied on the second (active word is 0).
    task automatic start_run(input logic [ACC_W-1:0] ftw, input int off);
        bus.i_offset   = OUT_W'(off);
        bus.i_ftw      = ftw;
        bus.i_ftw_load = 1'b1;
        bus.i_en       = 1'b1;
        step(off, 1'b0, 1'b1);
        bus.i_ftw_load = 1'b0;
        step(off, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        #2;
        reset_dut();

        tname = "ramp";
        start_run(32'h0010_0000, 0);
        for (int k = 0; k <= 4100; k++) step(k % 4096, k == 4096, 1'b0);

        tname = "retune";
        reset_dut();
        start_run(32'h1000_0000, 0);
        for (int k = 0; k <= 3; k++) step(256 * k, 1'b0, 1'b0);
        bus.i_ftw      = 32'h2000_0000;
        bus.i_ftw_load = 1'b1;
        step(1024, 1'b0, 1'b1);
        bus.i_ftw_load = 1'b0;
        for (int k = 5; k <= 15; k++) step(256 * k, 1'b0, k != 15);
        for (int j = 0; j <= 9; j++) step((512 * j) % 4096, (j == 0) || (j == 8), 1'b0);

        tname = "dc_offset";
        reset_dut();
        bus.i_offset = 12'd2048;
        bus.i_en     = 1'b1;
        repeat (5) step(2048, 1'b0, 1'b0);
        start_run(32'h0010_0000, 2048);
        step(2048, 1'b0, 1'b0);
        bus.i_en     = 1'b0;
        bus.i_offset = 12'd4095;
        step(0, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0);

        tname = "sync";
        reset_dut();
        start_run(32'h0010_0000, 100);
        for (int k = 0; k <= 5; k++) step(100 + k, 1'b0, 1'b0);
        bus.i_sync = 1'b1;
        step(106, 1'b0, 1'b0);
        bus.i_sync = 1'b0;
        for (int m = 0; m <= 3; m++) step(100 + m, 1'b0, 1'b0);
        bus.i_en   = 1'b0;
        bus.i_sync = 1'b1;
        step(104, 1'b0, 1'b0);
        bus.i_sync = 1'b0;
        step(100, 1'b0, 1'b0);
        step(100, 1'b0, 1'b0);

        tname = "hold";
        reset_dut();
        start_run(32'h0010_0000, 0);
        for (int k = 0; k <= 10; k++) step(k, 1'b0, 1'b0);
        bus.i_en = 1'b0;
        repeat (10) step(11, 1'b0, 1'b0);
        bus.i_en = 1'b1;
        step(11, 1'b0, 1'b0);
        step(12, 1'b0, 1'b0);
        bus.i_ftw      = 32'h0020_0000;
        bus.i_ftw_load = 1'b1;
        step(13, 1'b0, 1'b1);
        bus.i_ftw_load = 1'b0;

        tname = "async_rst";
        #3;
        rst = 1'b1;
        #1;
        chk("phase", 32'(bus.o_phase), 32'd0);
        chk("wrap", 32'(bus.o_wrap), 32'd0);
        chk("pend", 32'(bus.o_ftw_pending), 32'd0);
        #1;
        rst = 1'b0;

        tname = "half_lsb";
        reset_dut();
        start_run(32'h0008_0000, 0);
        for (int k = 0; k <= 9; k++) step(k / 2, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
